// File: rtl/disp_sched.sv
// Display scheduler for the 8-digit seven-segment clock display: mode/edit FSM,
// source selection, edit-field blinking, segment encoding and counter control pulses.
module disp_sched #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic        CP_100MHz,
    input  logic        CLR,
    input  logic        KEY_MODE,
    input  logic        KEY_SEL,
    input  logic        KEY_UP,
    input  logic [23:0] TIME_BCD,
    input  logic [23:0] ALM_BCD,
    input  logic [23:0] SW_BCD,
    output logic [6:0]  SEG7,
    output logic [6:0]  SEG6,
    output logic [6:0]  SEG5,
    output logic [6:0]  SEG4,
    output logic [6:0]  SEG3,
    output logic [6:0]  SEG2,
    output logic [6:0]  SEG1,
    output logic [6:0]  SEG0,
    output logic [7:0]  DOT,
    output logic [2:0]  INC_T,
    output logic [2:0]  INC_A,
    output logic        SW_RUN,
    output logic        SW_CLR
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [6:0] SEG_BLANK = 7'b111_1111;
    localparam logic [6:0] SEG_DASH  = 7'b011_1111;

    typedef enum logic [1:0] {M_TIME, M_ALARM, M_STOPWATCH} mode_t;
    typedef enum logic [1:0] {F_NONE, F_HR, F_MIN, F_SEC} field_t;

    function automatic logic [6:0] seg_encode(input logic [3:0] n);
        case (n)
            4'd0:    seg_encode = 7'b100_0000;
            4'd1:    seg_encode = 7'b111_1001;
            4'd2:    seg_encode = 7'b010_0100;
            4'd3:    seg_encode = 7'b011_0000;
            4'd4:    seg_encode = 7'b001_1001;
            4'd5:    seg_encode = 7'b001_0010;
            4'd6:    seg_encode = 7'b000_0010;
            4'd7:    seg_encode = 7'b111_1000;
            4'd8:    seg_encode = 7'b000_0000;
            4'd9:    seg_encode = 7'b001_0000;
            default: seg_encode = SEG_BLANK;
        endcase
    endfunction

    mode_t            r_mode, w_mode_next;
    field_t           r_field, w_field_next;
    logic [CNT_W-1:0] r_blink_cnt, w_blink_cnt_next;
    logic             r_phase, w_phase_next;
    logic             w_view_change;
    logic             r_sw_run, w_sw_run_next;
    logic             r_sw_clr, w_sw_clr_next;
    logic [2:0]       r_inc_t, w_inc_t_next;
    logic [2:0]       r_inc_a, w_inc_a_next;
    logic [2:0]       w_field_onehot;
    logic [7:0][6:0]  r_seg, w_seg_next;
    logic [7:0]       r_dot, w_dot_next;
    logic [23:0]      w_src;
    logic [6:0]       w_dig [6];

    // State register
    always_ff @(posedge CP_100MHz) begin
        if (CLR) begin
            r_mode      <= M_TIME;
            r_field     <= F_NONE;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_sw_run    <= 1'b0;
            r_sw_clr    <= 1'b0;
            r_inc_t     <= 3'b000;
            r_inc_a     <= 3'b000;
            r_seg       <= {8{SEG_BLANK}};
            r_dot       <= 8'h00;
        end else begin
            r_mode      <= w_mode_next;
            r_field     <= w_field_next;
            r_blink_cnt <= w_blink_cnt_next;
            r_phase     <= w_phase_next;
            r_sw_run    <= w_sw_run_next;
            r_sw_clr    <= w_sw_clr_next;
            r_inc_t     <= w_inc_t_next;
            r_inc_a     <= w_inc_a_next;
            r_seg       <= w_seg_next;
            r_dot       <= w_dot_next;
        end
    end

    // Next-state logic: KEY_MODE wins, then KEY_SEL; any view change restarts the blink
    always_comb begin
        w_mode_next   = r_mode;
        w_field_next  = r_field;
        w_view_change = 1'b0;
        if (KEY_MODE) begin
            case (r_mode)
                M_TIME:  w_mode_next = M_ALARM;
                M_ALARM: w_mode_next = M_STOPWATCH;
                default: w_mode_next = M_TIME;
            endcase
            w_field_next  = F_NONE;
            w_view_change = 1'b1;
        end else if (KEY_SEL && r_mode != M_STOPWATCH) begin
            w_field_next  = field_t'(r_field + 2'd1);
            w_view_change = 1'b1;
        end

        w_blink_cnt_next = r_blink_cnt + 1'b1;
        w_phase_next     = r_phase;
        if (w_view_change) begin
            w_blink_cnt_next = '0;
            w_phase_next     = 1'b0;
        end else if (r_blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
            w_blink_cnt_next = '0;
            w_phase_next     = ~r_phase;
        end
    end

    // Output logic: control pulses and display image
    always_comb begin
        case (r_field)
            F_HR:    w_field_onehot = 3'b100;
            F_MIN:   w_field_onehot = 3'b010;
            F_SEC:   w_field_onehot = 3'b001;
            default: w_field_onehot = 3'b000;
        endcase

        w_inc_t_next  = 3'b000;
        w_inc_a_next  = 3'b000;
        w_sw_clr_next = 1'b0;
        w_sw_run_next = r_sw_run;
        if (!KEY_MODE) begin
            if (KEY_SEL) begin
                if (r_mode == M_STOPWATCH) begin
                    w_sw_clr_next = 1'b1;
                    w_sw_run_next = 1'b0;
                end
            end else if (KEY_UP) begin
                case (r_mode)
                    M_TIME:  w_inc_t_next  = w_field_onehot;
                    M_ALARM: w_inc_a_next  = w_field_onehot;
                    default: w_sw_run_next = ~r_sw_run;
                endcase
            end
        end

        case (r_mode)
            M_ALARM:     w_src = ALM_BCD;
            M_STOPWATCH: w_src = SW_BCD;
            default:     w_src = TIME_BCD;
        endcase

        w_seg_next = {w_dig[5], w_dig[4], SEG_DASH, w_dig[3], w_dig[2], SEG_DASH, w_dig[1], w_dig[0]};
        w_dot_next = {r_sw_run, 5'b00000, r_mode == M_STOPWATCH, r_mode == M_ALARM};
    end

    // Digit gi belongs to field SEC (0,1), MIN (2,3) or HR (4,5)
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_digit
            localparam logic [1:0] PAIR_FIELD = 2'(3 - gi / 2);
            always_comb begin
                if (r_phase && r_field == PAIR_FIELD)
                    w_dig[gi] = SEG_BLANK;
                else
                    w_dig[gi] = seg_encode(w_src[gi*4 +: 4]);
            end
        end
    endgenerate

    assign {SEG7, SEG6, SEG5, SEG4, SEG3, SEG2, SEG1, SEG0} = r_seg;
    assign DOT    = r_dot;
    assign INC_T  = r_inc_t;
    assign INC_A  = r_inc_a;
    assign SW_RUN = r_sw_run;
    assign SW_CLR = r_sw_clr;

endmodule

// File: tb/tb_disp_sched.sv
// Bench for disp_sched: directed steps followed by random key/BCD traffic,
// every cycle compared against a behavioural model of the display controller.
module tb_disp_sched;

    logic        clk = 1'b0;
    logic        CLR = 1'b0, KEY_MODE = 1'b0, KEY_SEL = 1'b0, KEY_UP = 1'b0;
    logic [23:0] TIME_BCD = '0, ALM_BCD = '0, SW_BCD = '0;
    logic [6:0]  SEG7, SEG6, SEG5, SEG4, SEG3, SEG2, SEG1, SEG0;
    logic [7:0]  DOT;
    logic [2:0]  INC_T, INC_A;
    logic        SW_RUN, SW_CLR;

    int total = 0;
    int passes = 0;

    // Model state: mode 0=TIME 1=ALARM 2=STOPWATCH, field 0=NONE 1=HR 2=MIN 3=SEC
    int         m_mode = 0, m_field = 0, m_cnt = 0;
    bit         m_phase = 0, m_run = 0;
    logic [2:0] e_inc_t = 0, e_inc_a = 0;
    logic       e_clr = 0;
    logic [55:0] e_seg = {8{7'h7F}};
    logic [7:0]  e_dot = 0;

    localparam logic [6:0] ENC_TAB [0:9] = '{7'b100_0000, 7'b111_1001, 7'b010_0100,
        7'b011_0000, 7'b001_1001, 7'b001_0010, 7'b000_0010, 7'b111_1000,
        7'b000_0000, 7'b001_0000};

    always #5 clk = ~clk;

    disp_sched #(.BLINK_DIV(4)) dut (
        .CP_100MHz(clk), .CLR(CLR), .KEY_MODE(KEY_MODE), .KEY_SEL(KEY_SEL), .KEY_UP(KEY_UP),
        .TIME_BCD(TIME_BCD), .ALM_BCD(ALM_BCD), .SW_BCD(SW_BCD),
        .SEG7(SEG7), .SEG6(SEG6), .SEG5(SEG5), .SEG4(SEG4),
        .SEG3(SEG3), .SEG2(SEG2), .SEG1(SEG1), .SEG0(SEG0),
        .DOT(DOT), .INC_T(INC_T), .INC_A(INC_A), .SW_RUN(SW_RUN), .SW_CLR(SW_CLR)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [6:0] enc(input logic [3:0] n);
        logic [6:0] r;
        if (n > 4'd9) r = 7'b111_1111;
        else r = ENC_TAB[n];
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs sampled at that edge
    task automatic model_edge(input logic c, input logic km, input logic ks, input logic ku);
        logic [23:0] src;
        logic [6:0]  d [0:5];
        bit          changed;
        if (c) begin
            m_mode = 0; m_field = 0; m_cnt = 0; m_phase = 0; m_run = 0;
            e_inc_t = 0; e_inc_a = 0; e_clr = 0;
            e_seg = {8{7'h7F}}; e_dot = 0;
            return;
        end
        src = (m_mode == 1) ? ALM_BCD : (m_mode == 2) ? SW_BCD : TIME_BCD;
        for (int k = 0; k < 6; k++) begin
            // digits 0,1 = seconds (field 3), 2,3 = minutes (2), 4,5 = hours (1)
            if (m_phase && m_field == 3 - k / 2) d[k] = 7'h7F;
            else d[k] = enc(src[k*4 +: 4]);
        end
        e_seg = {d[5], d[4], 7'b011_1111, d[3], d[2], 7'b011_1111, d[1], d[0]};
        e_dot = {m_run, 5'b0, m_mode == 2, m_mode == 1};
        e_inc_t = 0; e_inc_a = 0; e_clr = 0; changed = 0;
        if (km) begin
            m_mode = (m_mode + 1) % 3; m_field = 0; changed = 1;
        end else if (ks) begin
            if (m_mode == 2) begin e_clr = 1; m_run = 0; end
            else begin m_field = (m_field + 1) % 4; changed = 1; end
        end else if (ku) begin
            if (m_mode == 2) m_run = !m_run;
            else if (m_field != 0) begin
                if (m_mode == 0) e_inc_t = 3'(1 << (3 - m_field));
                else e_inc_a = 3'(1 << (3 - m_field));
            end
        end
        if (changed) begin m_cnt = 0; m_phase = 0; end
        else if (m_cnt == 3) begin m_cnt = 0; m_phase = !m_phase; end
        else m_cnt++;
    endtask

    task automatic step(input logic c, input logic km, input logic ks, input logic ku);
        CLR = c; KEY_MODE = km; KEY_SEL = ks; KEY_UP = ku;
        @(posedge clk);
        model_edge(c, km, ks, ku);
        #1;
        check("seg", {8'h0, SEG7, SEG6, SEG5, SEG4, SEG3, SEG2, SEG1, SEG0}, {8'h0, e_seg});
        check("dot", 64'(DOT), 64'(e_dot));
        check("pulses", 64'({INC_T, INC_A, SW_CLR, SW_RUN}), 64'({e_inc_t, e_inc_a, e_clr, m_run}));
        CLR = 0; KEY_MODE = 0; KEY_SEL = 0; KEY_UP = 0;
    endtask

    initial begin
        int blanks;
        // Reset and idle decode of 12-34-56
        step(1, 0, 0, 0);
        check("reset_seg7", 64'(SEG7), 64'h7F);
        TIME_BCD = 24'h123456;
        step(0, 0, 0, 0);
        check("t1_seg7", 64'(SEG7), 64'(7'b111_1001));
        check("t1_seg0", 64'(SEG0), 64'(7'b000_0010));
        check("t1_dash", 64'({SEG5, SEG2}), 64'({7'b011_1111, 7'b011_1111}));

        // Mode cycling with distinct alarm value
        TIME_BCD = 24'h000000; ALM_BCD = 24'h070000; SW_BCD = 24'h000000;
        step(0, 1, 0, 0); step(0, 0, 0, 0);
        check("alarm_dot", 64'(DOT), 64'h01);
        check("alarm_seg6", 64'(SEG6), 64'(7'b111_1000));
        step(0, 1, 0, 0); step(0, 0, 0, 0);
        check("sw_dot", 64'(DOT), 64'h02);
        step(0, 1, 0, 0); step(0, 0, 0, 0);
        check("time_dot", 64'(DOT), 64'h00);

        // Edit HR, count blank cycles over 16, then increments
        TIME_BCD = 24'h123456;
        step(0, 0, 1, 0);
        blanks = 0;
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, 0);
            if (SEG7 == 7'h7F) blanks++;
        end
        check("blink_blanks", 64'(blanks), 64'd8);
        step(0, 0, 0, 1);
        check("inc_hr", 64'(INC_T), 64'(3'b100));
        step(0, 0, 0, 0);
        check("inc_hr_gone", 64'(INC_T), 64'd0);
        step(0, 0, 1, 0); step(0, 0, 0, 1);
        check("inc_min", 64'(INC_T), 64'(3'b010));
        step(0, 0, 1, 1);
        check("sel_over_up", 64'(INC_T), 64'd0);

        // Stopwatch run/clear, and KEY_MODE priority
        step(0, 1, 0, 0); step(0, 1, 0, 0);
        step(0, 0, 0, 1); step(0, 0, 0, 0);
        check("sw_run", 64'({SW_RUN, DOT[7]}), 64'b11);
        step(0, 0, 1, 0);
        check("sw_clr", 64'({SW_CLR, SW_RUN}), 64'b10);
        step(0, 0, 0, 1);
        step(0, 1, 0, 1); step(0, 0, 0, 0);
        check("mode_prio", 64'({SW_RUN, DOT[1:0]}), 64'b100);

        // Invalid nibbles blank
        TIME_BCD = 24'hAF0000;
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        check("bad_nibble", 64'({SEG7, SEG6, SEG4}), 64'({7'h7F, 7'h7F, 7'b100_0000}));

        // Reset mid-edit with stopwatch running
        step(0, 0, 1, 0); step(0, 0, 1, 0);
        step(1, 0, 0, 1);
        check("clr_all", 64'({SEG7, DOT, INC_T, SW_RUN}), 64'({7'h7F, 8'h00, 3'b000, 1'b0}));
        step(0, 0, 0, 1);
        check("clr_field_none", 64'(INC_T), 64'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic c, km, ks, ku;
            if ($urandom_range(0, 7) == 0) begin
                TIME_BCD = $urandom(); ALM_BCD = $urandom(); SW_BCD = $urandom();
            end
            c  = ($urandom_range(0, 99) == 0);
            km = ($urandom_range(0, 9) == 0);
            ks = ($urandom_range(0, 5) == 0);
            ku = ($urandom_range(0, 3) == 0);
            step(c, km, ks, ku);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
